wb_data_cache: RTL and testbench

WB_DATA_CACHE -- requirements
Module: wb_data_cache

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_line_array.sv | 57 +++++
 rtl/wb_data_cache.sv | 102 ++++++++++
 tb/tb_wb_data_cache.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry constants, FSM state encoding and byte-select helper for the
// write-back data cache.
package cache_pkg;

    localparam int unsigned TAG_W   = 3;
    localparam int unsigned INDEX_W = 3;
    localparam int unsigned LINES   = 8;
    localparam int unsigned BLOCK_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWriteBack,
        StMemRead,
        StUpdate
    } cache_state_e;

    // Offset 0 lives in the least significant byte of the block.
    function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0] blk,
                                               input logic [1:0]         off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: valid/dirty flags, tags, data blocks
// and the combinational hit compare for the addressed line.
module cache_line_array
    import cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [1:0]         offset_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_we_i,
    input  logic               fill_i,
    input  logic [BLOCK_W-1:0] fill_data_i,
    output logic               hit_o,
    output logic               line_valid_o,
    output logic               line_dirty_o,
    output logic [TAG_W-1:0]   line_tag_o,
    output logic [BLOCK_W-1:0] line_data_o
);

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign line_valid_o = valid_q[index_i];
    assign line_dirty_o = dirty_q[index_i];
    assign line_tag_o   = tag_q[index_i];
    assign line_data_o  = data_q[index_i];
    assign hit_o        = valid_q[index_i] && (tag_q[index_i] == tag_i);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Tags and data need no reset: they are ignored while the valid bit is clear.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fill_i) begin
                tag_q[index_i]  <= tag_i;
                data_q[index_i] <= fill_data_i;
            end else if (byte_we_i) begin
                data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_i;
            end
        end
    end

endmodule

// File: rtl/wb_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: miss FSM, CPU port and
// block-level memory port around the cache_line_array storage.
module wb_data_cache
    import cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               read,
    input  logic               write,
    input  logic [7:0]         address,
    input  logic [7:0]         writedata,
    output logic [7:0]         readdata,
    output logic               busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [5:0]         mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    cache_state_e state_q, state_d;

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         offset;
    logic               access;
    logic               hit;
    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               fill;
    logic               byte_we;

    assign tag    = address[7:5];
    assign index  = address[4:2];
    assign offset = address[1:0];
    assign access = read | write;

    cache_line_array u_lines (
        .CLK          (CLK),
        .RESET        (RESET),
        .index_i      (index),
        .tag_i        (tag),
        .offset_i     (offset),
        .byte_i       (writedata),
        .byte_we_i    (byte_we),
        .fill_i       (fill),
        .fill_data_i  (mem_readdata),
        .hit_o        (hit),
        .line_valid_o (line_valid),
        .line_dirty_o (line_dirty),
        .line_tag_o   (line_tag),
        .line_data_o  (line_data)
    );

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        fill          = 1'b0;
        byte_we       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !hit) begin
                    state_d = (line_valid && line_dirty) ? StWriteBack : StMemRead;
                end else if (write && hit) begin
                    byte_we = 1'b1;
                end
            end
            StWriteBack: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, index};
                mem_writedata = line_data;
                if (!mem_busywait) state_d = StMemRead;
            end
            StMemRead: begin
                mem_read    = 1'b1;
                mem_address = address[7:2];
                if (!mem_busywait) state_d = StUpdate;
            end
            StUpdate: begin
                fill    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // After UPDATE the still-held request is retried in IDLE and hits.
    assign busywait = (access && !hit) || (state_q != StIdle);
    assign readdata = (read && hit) ? select_byte(line_data, offset) : 8'h00;

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= StIdle;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_wb_data_cache.sv
// Scoreboard bench for wb_data_cache: stimulus queues expected accesses and memory
// requests, a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    always #5 CLK = ~CLK;

    wb_data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    typedef struct {
        logic       is_write;
        logic [7:0] data;
        int         stalls;
    } acc_exp_t;

    typedef struct {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    acc_exp_t    acc_q[$];
    mem_exp_t    mreq_q[$];
    logic [31:0] mem [64];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: three-count busy period per request, data moves when busy drops.
    logic mem_active, mem_kind;
    int   mem_cnt;
    initial begin
        mem_busywait = 1'b0;
        mem_readdata = '0;
        mem_active   = 1'b0;
        mem_kind     = 1'b0;
        mem_cnt      = 0;
        forever begin
            @(negedge CLK);
            if (mem_read || mem_write) begin
                if (!mem_active || mem_kind !== mem_write) begin
                    mem_active   = 1'b1;
                    mem_kind     = mem_write;
                    mem_cnt      = 3;
                    mem_busywait = 1'b1;
                end else if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        mem_busywait = 1'b0;
                        if (mem_write) mem[mem_address] = mem_writedata;
                        else           mem_readdata = mem[mem_address];
                    end
                end
            end else begin
                mem_active   = 1'b0;
                mem_busywait = 1'b0;
            end
        end
    end

    // Monitor: memory-request starts and CPU access completions.
    int       stall_cnt;
    logic     prev_mr, prev_mw;
    acc_exp_t ae;
    mem_exp_t me;
    initial begin
        stall_cnt = 0;
        prev_mr   = 1'b0;
        prev_mw   = 1'b0;
        forever begin
            @(negedge CLK);
            if (mem_read && mem_write) begin
                checks++;
                failures++;
                $display("FAIL mem_exclusive: got mem_read=1 mem_write=1 expected at most one");
            end
            if (RESET) begin
                stall_cnt = 0;
            end else begin
                if ((mem_read && !prev_mr) || (mem_write && !prev_mw)) begin
                    if (mreq_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_req_unexpected: got addr %0h expected none", mem_address);
                    end else begin
                        me = mreq_q.pop_front();
                        check("mem_req_kind", {31'd0, mem_write}, {31'd0, me.is_write});
                        check("mem_req_addr", {26'd0, mem_address}, {26'd0, me.addr});
                        if (me.is_write) check("mem_req_wdata", mem_writedata, me.data);
                    end
                end
                if (read || write) begin
                    if (busywait) begin
                        stall_cnt++;
                    end else begin
                        if (acc_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL access_unexpected: got completion expected none");
                        end else begin
                            ae = acc_q.pop_front();
                            check("stall_cycles", stall_cnt, ae.stalls);
                            if (!ae.is_write) check("readdata", {24'd0, readdata}, {24'd0, ae.data});
                        end
                        stall_cnt = 0;
                    end
                end
            end
            prev_mr = mem_read;
            prev_mw = mem_write;
        end
    end

    task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
        mreq_q.push_back('{is_write: wr, addr: a, data: d});
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_data,
                          input int exp_stalls);
        int n;
        acc_q.push_back('{is_write: wr, data: exp_data, stalls: exp_stalls});
        @(posedge CLK);
        #1;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busywait && n < 100);
        if (busywait) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: got busywait=1 after %0d cycles expected 0", n);
        end
        @(posedge CLK);
        #1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge CLK);
        check("idle_readdata", {24'd0, readdata}, 32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        for (int i = 0; i < 64; i++) mem[i] = {4{i[7:0]}};
        mem[1] = 32'h44332211;
        mem[9] = 32'h87654321;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_readdata", {24'd0, readdata}, 32'd0);
        check("rst_busywait", {31'd0, busywait}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_address", {26'd0, mem_address}, 32'd0);
        check("rst_mem_writedata", mem_writedata, 32'd0);

        push_mem(1'b0, 6'h01, '0);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 6);
        access(1'b1, 1'b0, 8'h07, 8'h00, 8'h44, 0);
        access(1'b0, 1'b1, 8'h04, 8'hAA, 8'h00, 0);
        access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 0);
        push_mem(1'b1, 6'h01, 32'h443322AA);
        push_mem(1'b0, 6'h09, '0);
        access(1'b1, 1'b0, 8'h24, 8'h00, 8'h21, 10);
        access(1'b1, 1'b0, 8'h27, 8'h00, 8'h87, 0);
        push_mem(1'b0, 6'h02, '0);
        access(1'b0, 1'b1, 8'h0B, 8'h55, 8'h00, 6);
        access(1'b1, 1'b0, 8'h0B, 8'h00, 8'h55, 0);
        access(1'b1, 1'b1, 8'h08, 8'h66, 8'h00, 0);
        access(1'b1, 1'b0, 8'h08, 8'h00, 8'h66, 0);
        push_mem(1'b1, 6'h02, 32'h55020266);
        push_mem(1'b0, 6'h12, '0);
        access(1'b1, 1'b0, 8'h48, 8'h00, 8'h12, 10);

        // Reset lands while the fetch for 0x05 is outstanding.
        push_mem(1'b0, 6'h01, '0);
        @(posedge CLK);
        #1;
        read    = 1'b1;
        address = 8'h05;
        begin
            int n;
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!mem_read && n < 100);
            if (!mem_read) begin
                checks++;
                failures++;
                $display("FAIL abort_wait_mem_read: got mem_read=0 expected 1");
            end
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        read  = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("abort_busywait", {31'd0, busywait}, 32'd0);
        push_mem(1'b0, 6'h01, '0);
        access(1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 6);

        repeat (3) @(negedge CLK);
        check("acc_queue_empty", acc_q.size(), 32'd0);
        check("mem_queue_empty", mreq_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
